// File: rtl/dac_mixer.sv
// Sequential multi-source stereo mixer: sum, shift, saturate, queue for the DAC.
// Optional clip_count counter is built when DAC_MIXER_CLIP_COUNT_EN is defined.
module dac_mixer #(
  parameter int NUM_INPUTS = 2,
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 24,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [NUM_INPUTS*IN_WIDTH-1:0]    in_l,
  input  logic [NUM_INPUTS*IN_WIDTH-1:0]    in_r,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OUT_WIDTH-1:0]              out_l,
  output logic [OUT_WIDTH-1:0]              out_r,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_level,
  output logic                              clipped,
  output logic                              overflow,
  output logic [15:0]                       clip_count
);

  localparam int SW = IN_WIDTH + $clog2(NUM_INPUTS);
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int WW = (((SW + SHIFT) > OUT_WIDTH) ? (SW + SHIFT) : OUT_WIDTH) + 1;

  localparam logic signed [WW-1:0] MAXV = {{(WW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] MINV = ~MAXV;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] SAT   = 2'd2;

  logic [1:0]                      state;
  logic [IW-1:0]                   idx;
  logic [NUM_INPUTS*IN_WIDTH-1:0]  hold_l, hold_r;
  logic signed [SW-1:0]            acc_l, acc_r;
  logic signed [IN_WIDTH-1:0]      src_l, src_r;

  logic [OUT_WIDTH-1:0] mem_l [FIFO_DEPTH];
  logic [OUT_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level;
  logic [OUT_WIDTH-1:0] last_l, last_r;

  logic [OUT_WIDTH:0]   sat_l, sat_r;
  logic                 clip_any, push_req, do_push, do_pop, full;

  // Returns {saturated, value} for a final accumulator value.
  function automatic logic [OUT_WIDTH:0] sat_fn(input logic signed [SW-1:0] a);
    logic signed [WW-1:0] s;
    s = WW'(a) <<< SHIFT;
    if (s > MAXV)      return {1'b1, MAXV[OUT_WIDTH-1:0]};
    else if (s < MINV) return {1'b1, MINV[OUT_WIDTH-1:0]};
    else               return {1'b0, s[OUT_WIDTH-1:0]};
  endfunction

  always_comb begin
    src_l = '0;
    src_r = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (idx == IW'(k)) begin
        src_l = hold_l[k*IN_WIDTH +: IN_WIDTH];
        src_r = hold_r[k*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  always_comb begin
    sat_l    = sat_fn(acc_l);
    sat_r    = sat_fn(acc_r);
    clip_any = sat_l[OUT_WIDTH] | sat_r[OUT_WIDTH];
    push_req = (state == SAT);
    full     = (level == LW'(FIFO_DEPTH));
    do_pop   = out_ready && (level != '0);
    do_push  = push_req && (!full || do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      hold_l   <= '0;
      hold_r   <= '0;
      acc_l    <= '0;
      acc_r    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      last_l   <= '0;
      last_r   <= '0;
      clipped  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          hold_l <= in_l;
          hold_r <= in_r;
          acc_l  <= '0;
          acc_r  <= '0;
          idx    <= '0;
          state  <= ACCUM;
        end
        ACCUM: begin
          acc_l <= acc_l + SW'(src_l);
          acc_r <= acc_r + SW'(src_r);
          if (idx == IW'(NUM_INPUTS-1)) state <= SAT;
          else                          idx   <= idx + IW'(1);
        end
        SAT:     state <= IDLE;
        default: state <= IDLE;
      endcase

      if ((in_valid && state != IDLE) || (push_req && !do_push)) overflow <= 1'b1;
      if (push_req && clip_any) clipped <= 1'b1;

      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) begin
        last_l <= mem_l[rd_ptr];
        last_r <= mem_r[rd_ptr];
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: empty FIFO shows last_l/last_r instead of mem.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      mem_l[wr_ptr] <= sat_l[OUT_WIDTH-1:0];
      mem_r[wr_ptr] <= sat_r[OUT_WIDTH-1:0];
    end
  end

  assign out_valid  = (level != '0);
  assign out_l      = out_valid ? mem_l[rd_ptr] : last_l;
  assign out_r      = out_valid ? mem_r[rd_ptr] : last_r;
  assign fifo_level = level;

`ifdef DAC_MIXER_CLIP_COUNT_EN
  logic [15:0] clip_cnt;
  always_ff @(posedge clk) begin
    if (reset)                                          clip_cnt <= '0;
    else if (push_req && clip_any && clip_cnt != '1)    clip_cnt <= clip_cnt + 16'd1;
  end
  assign clip_count = clip_cnt;
`else
  assign clip_count = '0;
`endif

endmodule

// File: tb/tb_dac_mixer.sv
// Randomized bench for dac_mixer against a transaction-level model of sum/saturate/FIFO.
module tb_dac_mixer;
  localparam int NI = 2, IN_W = 16, OUT_W = 24, SH = 8, DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic [NI*IN_W-1:0]   in_l, in_r;
  logic                 out_valid, out_ready;
  logic signed [OUT_W-1:0] out_l, out_r;
  logic [$clog2(DEPTH):0]  fifo_level;
  logic                 clipped, overflow;
  logic [15:0]          clip_count;

  dac_mixer #(.NUM_INPUTS(NI), .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .SHIFT(SH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_l(in_l), .in_r(in_r),
    .out_valid(out_valid), .out_ready(out_ready), .out_l(out_l), .out_r(out_r),
    .fifo_level(fifo_level), .clipped(clipped), .overflow(overflow), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { longint l; longint r; } sample_t;
  sample_t q[$];
  longint  m_last_l = 0, m_last_r = 0;
  bit      m_clipped = 0, m_ovf = 0, armed = 0;
  int      m_cnt = 0, cyc = 0;
  bit      pend = 0;
  int      pend_due = 0;
  longint  pend_l = 0, pend_r = 0;
  bit      pend_clip = 0;

  function automatic void mix(input logic [NI*IN_W-1:0] v, output longint val, output bit clip);
    longint sum = 0;
    longint scaled, maxv, minv;
    logic signed [IN_W-1:0] s;
    for (int k = 0; k < NI; k++) begin
      s = v[k*IN_W +: IN_W];
      sum += s;
    end
    scaled = sum * (longint'(1) << SH);
    maxv = (longint'(1) << (OUT_W-1)) - 1;
    minv = -(longint'(1) << (OUT_W-1));
    clip = 1'b0;
    val  = scaled;
    if (scaled > maxv) begin val = maxv; clip = 1'b1; end
    if (scaled < minv) begin val = minv; clip = 1'b1; end
  endfunction

  task automatic model_step();
    bit pop, push, busy, cl, cr;
    sample_t e;
    if (reset) begin
      q.delete();
      m_last_l = 0; m_last_r = 0; m_clipped = 0; m_ovf = 0; m_cnt = 0; pend = 0;
      armed = 1;
    end else begin
      pop  = out_ready && q.size() > 0;
      push = pend && cyc == pend_due;
      busy = pend;
      if (push) begin
        if (q.size() < DEPTH || pop) begin
          e.l = pend_l; e.r = pend_r; q.push_back(e);
        end else m_ovf = 1;
        if (pend_clip) begin
          m_clipped = 1;
          if (m_cnt < 65535) m_cnt++;
        end
        pend = 0;
      end
      if (pop) begin
        m_last_l = q[0].l; m_last_r = q[0].r;
        q.pop_front();
      end
      if (in_valid) begin
        if (busy) m_ovf = 1;
        else begin
          mix(in_l, pend_l, cl);
          mix(in_r, pend_r, cr);
          pend_clip = cl | cr;
          pend_due = cyc + NI + 1;
          pend = 1;
        end
      end
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  always @(negedge clk) begin
    if (armed) begin
      check("out_valid", out_valid, q.size() > 0);
      check("fifo_level", fifo_level, q.size());
      check("out_l", out_l, q.size() > 0 ? q[0].l : m_last_l);
      check("out_r", out_r, q.size() > 0 ? q[0].r : m_last_r);
      check("clipped", clipped, m_clipped);
      check("overflow", overflow, m_ovf);
`ifdef DAC_MIXER_CLIP_COUNT_EN
      check("clip_count", clip_count, m_cnt);
`else
      check("clip_count", clip_count, 0);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [NI*IN_W-1:0] l, input logic [NI*IN_W-1:0] r);
    in_l = l; in_r = r; in_valid = 1'b1;
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      in_valid = 1'b1; in_l = $urandom; in_r = $urandom;
      tick(1);
    end
    reset = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_l = '0; in_r = '0; out_ready = 1'b0;
    tick(1);
    do_reset(3);
    check("lit_reset_valid", out_valid, 0);
    check("lit_reset_level", fifo_level, 0);
    check("lit_reset_out_l", out_l, 0);

    // Basic: sources {100,200} left, {-50,-50} right
    pulse({16'sd200, 16'sd100}, {16'hFFCE, 16'hFFCE});
    tick(2);
    check("lit_basic_not_yet", out_valid, 0);
    tick(1);
    check("lit_basic_valid", out_valid, 1);
    check("lit_basic_l", out_l, 76800);
    check("lit_basic_r", out_r, -25600);
    check("lit_basic_clip", clipped, 0);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;

    // Saturation
    pulse({16'h7FFF, 16'h7FFF}, {16'h8000, 16'h8000});
    tick(3);
    check("lit_sat_l", out_l, 8388607);
    check("lit_sat_r", out_r, -8388608);
    check("lit_sat_clip", clipped, 1);
`ifdef DAC_MIXER_CLIP_COUNT_EN
    check("lit_sat_count", clip_count, 1);
`endif
    out_ready = 1'b1; tick(1); out_ready = 1'b0;

    // Backpressure: 5 inputs into a 4-deep FIFO
    for (int i = 0; i < 5; i++) begin
      pulse($urandom, $urandom);
      tick(3);
    end
    check("lit_bp_level", fifo_level, 4);
    check("lit_bp_ovf", overflow, 1);
    out_ready = 1'b1; tick(4); out_ready = 1'b0;
    check("lit_bp_drained", fifo_level, 0);
    check("lit_bp_valid", out_valid, 0);

    // Busy drop
    do_reset(1);
    pulse({16'sd2, 16'sd1}, {16'sd0, 16'sd0});
    tick(1);
    pulse($urandom, $urandom);
    tick(2);
    check("lit_busy_ovf", overflow, 1);
    check("lit_busy_level", fifo_level, 1);
    check("lit_busy_l", out_l, 768);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;

    // Full with simultaneous pop
    for (int i = 0; i < 4; i++) begin
      pulse($urandom, $urandom);
      tick(3);
    end
    pulse({16'sd4, 16'sd3}, {16'sd1, 16'sd1});
    tick(2);
    out_ready = 1'b1; tick(1); out_ready = 1'b0;
    check("lit_fullpop_level", fifo_level, 4);
    out_ready = 1'b1; tick(3);
    check("lit_fullpop_last", out_l, 1792);
    tick(1); out_ready = 1'b0;

    // Reset during accumulation
    pulse($urandom, $urandom);
    tick(1);
    do_reset(1);
    tick(1);
    pulse({16'sd10, 16'sd10}, {16'sd5, 16'sd5});
    tick(3);
    check("lit_midrst_level", fifo_level, 1);
    check("lit_midrst_l", out_l, 5120);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) == 0);
      in_l      = ($urandom_range(0, 3) == 0) ? {2{16'h7FFF}} : $urandom;
      in_r      = ($urandom_range(0, 3) == 0) ? {2{16'h8000}} : $urandom;
      out_ready = $urandom_range(0, 2) == 0;
      reset     = ($urandom_range(0, 149) == 0);
      tick(1);
    end
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
